program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer.sv | 114 +++++++++++
 tb/tb_program_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Program sequencer: fetches 9-bit words from a small loadable program memory,
// issues data words to a datapath with a ready handshake and executes jumps/halt itself.
module program_sequencer #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [8:0]        load_data,
  input  logic              start,
  input  logic              stop,
  input  logic              dp_ready,
  input  logic              flag,
  output logic [7:0]        instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, ISSUE, DONE} state_t;

  state_t            state;
  logic [8:0]        ir;
  logic [8:0]        mem [DEPTH];
  logic [ADDR_W-1:0] pc_next_seq;
  logic [ADDR_W-1:0] target;

  assign pc_next_seq = pc + ADDR_W'(1);
  assign target      = ir[ADDR_W-1:0];

  // Program memory comes out of reset filled with HALT so an unloaded run ends at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 9'h100;
    end else if (load_en && state == IDLE) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      ir          <= 9'h000;
      instr       <= 8'h00;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      instr       <= 8'h00;
      instr_valid <= 1'b0;
      if (stop && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              pc    <= '0;
              state <= FETCH;
              busy  <= 1'b1;
            end
          end
          FETCH: begin
            ir    <= mem[pc];
            state <= EXEC;
          end
          EXEC: begin
            if (!ir[8]) begin
              instr       <= ir[7:0];
              instr_valid <= 1'b1;
              state       <= ISSUE;
            end else begin
              state <= FETCH;
              case (ir[7:6])
                2'b00: begin
                  state <= DONE;
                  done  <= 1'b1;
                end
                2'b01: pc <= target;
                2'b10: pc <= flag ? target : pc_next_seq;
                2'b11: pc <= flag ? pc_next_seq : target;
              endcase
            end
          end
          ISSUE: begin
            // Word stays on instr until the datapath takes it.
            if (dp_ready) begin
              pc    <= pc_next_seq;
              state <= FETCH;
            end else begin
              instr       <= ir[7:0];
              instr_valid <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed vector table, hand-written corner sequences,
// and random programs checked against an instruction-level interpreter.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_en = 1'b0;
  logic [3:0] load_addr = 4'd0;
  logic [8:0] load_data = 9'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       dp_ready = 1'b0;
  logic       flag = 1'b0;
  logic [7:0] instr;
  logic       instr_valid;
  logic [3:0] pc;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail = 0;

  logic [8:0] prog [16];
  logic [7:0] exp_q[$];
  logic [3:0] exp_hpc;
  int         exp_cyc;

  typedef struct {
    logic [8:0] p [5];
    logic       flg;
    int         n;
    logic [7:0] e [3];
    logic [3:0] hpc;
    int         cyc;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  program_sequencer #(.ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stop(stop), .dp_ready(dp_ready),
    .flag(flag), .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic set_vec(input int i, input logic [8:0] p0, p1, p2, p3, p4, input logic flg,
                         input int n, input logic [7:0] e0, e1, e2, input logic [3:0] hpc,
                         input int cyc);
    vecs[i].p[0] = p0; vecs[i].p[1] = p1; vecs[i].p[2] = p2;
    vecs[i].p[3] = p3; vecs[i].p[4] = p4;
    vecs[i].flg = flg; vecs[i].n = n;
    vecs[i].e[0] = e0; vecs[i].e[1] = e1; vecs[i].e[2] = e2;
    vecs[i].hpc = hpc; vecs[i].cyc = cyc;
  endtask

  task automatic load_prog();
    for (int a = 0; a < 16; a++) begin
      load_en = 1'b1; load_addr = 4'(a); load_data = prog[a];
      @(negedge clk);
    end
    load_en = 1'b0;
  endtask

  task automatic kick(input logic ld, input logic [8:0] w0);
    start = 1'b1; load_en = ld; load_addr = 4'd0; load_data = w0;
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
  endtask

  // Cycle k=0 is the first cycle after the start edge.
  task automatic observe_run(input string tag);
    logic [7:0] got[$];
    int kdone;
    kdone = -1;
    for (int k = 0; k < 400; k++) begin
      if (instr_valid && dp_ready) got.push_back(instr);
      if (done) begin
        kdone = k;
        break;
      end
      @(negedge clk);
    end
    check({tag, " done-cycle"}, 32'(kdone), 32'(exp_cyc));
    check({tag, " issue-count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check({tag, " instr"}, 32'(got[i]), 32'(exp_q[i]));
    check({tag, " halt-pc"}, 32'(pc), 32'(exp_hpc));
    @(negedge clk);
    check({tag, " idle-after"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " valid-seen"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done-seen"}, 32'(done), 32'd1);
  endtask

  // Interpreter: data word costs 3 cycles, taken/untaken jump 2, HALT 2 before the done cycle.
  task automatic model(output bit ok);
    int   p;
    int   cyc;
    bit   taken;
    logic [8:0] w;
    p = 0; cyc = 0; ok = 1'b0;
    exp_q.delete();
    for (int s = 0; s < 60; s++) begin
      w = prog[p];
      if (!w[8]) begin
        exp_q.push_back(w[7:0]);
        cyc += 3;
        p = (p + 1) % 16;
      end else if (w[7:6] == 2'b00) begin
        exp_hpc = 4'(p);
        exp_cyc = cyc + 2;
        ok = 1'b1;
        return;
      end else begin
        cyc += 2;
        taken = (w[7:6] == 2'b01) || (w[7:6] == 2'b10 && flag) || (w[7:6] == 2'b11 && !flag);
        p = taken ? int'(w[3:0]) : (p + 1) % 16;
      end
    end
  endtask

  initial begin
    bit ok;
    logic seen;
    int r;

    set_vec(0, 9'h100, 9'h100, 9'h100, 9'h100, 9'h100, 1'b0, 0, 8'h00, 8'h00, 8'h00, 4'd0, 2);
    set_vec(1, 9'h001, 9'h081, 9'h100, 9'h100, 9'h100, 1'b0, 2, 8'h01, 8'h81, 8'h00, 4'd2, 8);
    set_vec(2, 9'h183, 9'h00A, 9'h100, 9'h0C0, 9'h100, 1'b1, 1, 8'hC0, 8'h00, 8'h00, 4'd4, 7);
    set_vec(3, 9'h183, 9'h00A, 9'h100, 9'h0C0, 9'h100, 1'b0, 1, 8'h0A, 8'h00, 8'h00, 4'd2, 7);
    set_vec(4, 9'h1C3, 9'h00A, 9'h100, 9'h0C0, 9'h100, 1'b0, 1, 8'hC0, 8'h00, 8'h00, 4'd4, 7);
    set_vec(5, 9'h142, 9'h011, 9'h022, 9'h100, 9'h100, 1'b1, 1, 8'h22, 8'h00, 8'h00, 4'd3, 7);

    // Reset values
    repeat (2) @(negedge clk);
    check("reset outputs", {19'd0, instr, instr_valid, pc, busy, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Memory after reset holds HALT everywhere
    dp_ready = 1'b1;
    exp_q.delete(); exp_hpc = 4'd0; exp_cyc = 2;
    kick(1'b0, 9'h000);
    observe_run("empty");

    for (int v = 0; v < 6; v++) begin
      for (int a = 0; a < 16; a++) prog[a] = (a < 5) ? vecs[v].p[a] : 9'h100;
      load_prog();
      flag = vecs[v].flg;
      exp_q.delete();
      for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(vecs[v].e[i]);
      exp_hpc = vecs[v].hpc;
      exp_cyc = vecs[v].cyc;
      kick(1'b0, 9'h000);
      observe_run($sformatf("vec%0d", v));
    end

    for (int it = 0; it < 20; it++) begin
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
        for (int a = 0; a < 16; a++) begin
          r = $urandom_range(0, 9);
          if (r < 5)      prog[a] = {1'b0, 8'($urandom)};
          else if (r < 7) prog[a] = {1'b1, 2'b00, 6'($urandom)};
          else            prog[a] = {1'b1, 2'($urandom_range(1, 3)), 6'($urandom)};
        end
        flag = 1'($urandom);
        model(ok);
      end
      if (ok) begin
        load_prog();
        kick(1'b0, 9'h000);
        observe_run($sformatf("rand%0d", it));
      end
    end

    // Stall: word held while dp_ready is low
    for (int a = 0; a < 16; a++) prog[a] = 9'h100;
    prog[0] = 9'h0B2;
    load_prog();
    dp_ready = 1'b0;
    kick(1'b0, 9'h000);
    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      check("stall hold", {22'd0, instr_valid, instr, 1'b0}, {22'd0, 1'b1, 8'hB2, 1'b0});
      check("stall pc", 32'(pc), 32'd0);
      if (i < 4) @(negedge clk);
    end
    dp_ready = 1'b1;
    @(negedge clk);
    check("stall release valid", 32'(instr_valid), 32'd0);
    check("stall release pc", 32'(pc), 32'd1);
    wait_done("stall");
    check("stall halt pc", 32'(pc), 32'd1);
    @(negedge clk);

    // JMP 15, wrap to 0, then stop during ISSUE
    for (int a = 0; a < 16; a++) prog[a] = 9'h100;
    prog[0] = 9'h14F;
    prog[15] = 9'h001;
    load_prog();
    dp_ready = 1'b1;
    kick(1'b0, 9'h000);
    wait_valid("wrap");
    check("wrap instr", 32'(instr), 32'h01);
    check("wrap pc15", 32'(pc), 32'd15);
    @(negedge clk);
    check("wrap pc0", 32'(pc), 32'd0);
    wait_valid("wrap rerun");
    check("wrap rerun instr", 32'(instr), 32'h01);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop state", {29'd0, instr_valid, busy, done}, 32'd0);
    check("stop pc", 32'(pc), 32'd15);
    seen = 1'b0;
    repeat (4) begin
      seen |= done | busy;
      @(negedge clk);
    end
    check("stop stays idle", 32'(seen), 32'd0);

    // load_en while busy has no effect
    for (int a = 0; a < 16; a++) prog[a] = 9'h100;
    prog[0] = 9'h011;
    prog[1] = 9'h022;
    load_prog();
    dp_ready = 1'b0;
    kick(1'b0, 9'h000);
    wait_valid("busyload");
    load_en = 1'b1; load_addr = 4'd1; load_data = 9'h0FF;
    @(negedge clk);
    load_en = 1'b0;
    dp_ready = 1'b1;
    @(negedge clk);
    wait_valid("busyload second");
    check("busyload second instr", 32'(instr), 32'h22);
    wait_done("busyload");
    @(negedge clk);
    exp_q.delete(); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_hpc = 4'd2; exp_cyc = 8;
    kick(1'b0, 9'h000);
    observe_run("busyload rerun");

    // load_en together with start: FETCH sees the new word
    exp_q.delete(); exp_q.push_back(8'h33); exp_q.push_back(8'h22);
    exp_hpc = 4'd2; exp_cyc = 8;
    kick(1'b1, 9'h033);
    observe_run("loadstart");

    // Asynchronous reset in ISSUE
    dp_ready = 1'b0;
    kick(1'b0, 9'h000);
    wait_valid("asyncrst");
    reset = 1'b1;
    #1;
    check("asyncrst outputs", {19'd0, instr, instr_valid, pc, busy, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    dp_ready = 1'b1;
    exp_q.delete(); exp_hpc = 4'd0; exp_cyc = 2;
    kick(1'b0, 9'h000);
    observe_run("post-reset empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
